sa_result_drain: RTL and testbench

Output drain stage directly downstream of the 1-level sum-apart MAC engine. It accepts one 48-bit accumulated result per valid/ready handshake and splits it into precision-dependent lanes (4×12b, 2×24b or 1×48b). Each lane is requantized by a programmable right shift with unsigned saturation to 8 bits, and the lanes are streamed out as a byte-serial valid/ready stream with a last marker. A wrapping count of drained results is kept for bring-up and debug.

---
 rtl/sa_result_drain.sv | 147 ++++++++++++++
 tb/tb_sa_result_drain.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// Drain stage after the sum-apart MAC engine: splits a 48-bit result into
// precision lanes, requantizes each lane to a saturated byte and streams them out.
module sa_result_drain #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_sum,
  input  logic [3:0]       mode,
  input  logic [5:0]       shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_sat,
  output logic             mode_err,
  output logic [CNT_W-1:0] result_cnt
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [47:0]      sum_q, sum_d;
  logic [1:0]       wsel_q, wsel_d;   // 0: 12b lanes, 1: 24b lanes, 2: one 48b lane
  logic [1:0]       last_q, last_d;   // index of the final lane (L-1)
  logic [5:0]       shift_q, shift_d;
  logic [1:0]       idx_q, idx_d;
  logic             mode_err_q, mode_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       dec_wsel;
  logic [1:0]       dec_last;
  logic             dec_err;

  always_comb begin
    dec_wsel = 2'd2;
    dec_last = 2'd0;
    dec_err  = 1'b0;
    case (mode)
      4'd0: begin dec_wsel = 2'd0; dec_last = 2'd3; end
      4'd1: begin dec_wsel = 2'd1; dec_last = 2'd1; end
      4'd2: ;
      default: dec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    wsel_d     = wsel_q;
    last_d     = last_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    mode_err_d = mode_err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = EMIT;
          sum_d      = in_sum;
          wsel_d     = dec_wsel;
          last_d     = dec_last;
          shift_d    = shift;
          idx_d      = 2'd0;
          mode_err_d = mode_err_q | dec_err;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == last_q) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      wsel_q     <= 2'd2;
      last_q     <= 2'd0;
      shift_q    <= '0;
      idx_q      <= '0;
      mode_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      wsel_q     <= wsel_d;
      last_q     <= last_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      mode_err_q <= mode_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Lane select and requantization, all from captured state
  logic [5:0]  lane_lo;
  logic [5:0]  lane_w;
  logic [47:0] lane;
  logic [47:0] shifted;
  logic        sat;

  always_comb begin
    lane_lo = 6'd0;
    lane_w  = 6'd48;
    lane    = sum_q;
    case (wsel_q)
      2'd0: begin
        lane_w = 6'd12;
        case (idx_q)
          2'd0: lane_lo = 6'd0;
          2'd1: lane_lo = 6'd12;
          2'd2: lane_lo = 6'd24;
          default: lane_lo = 6'd36;
        endcase
        lane = {36'd0, sum_q[lane_lo +: 12]};
      end
      2'd1: begin
        lane_w  = 6'd24;
        lane_lo = idx_q[0] ? 6'd24 : 6'd0;
        lane    = {24'd0, sum_q[lane_lo +: 24]};
      end
      default: ;
    endcase
    shifted = (shift_q >= lane_w) ? 48'd0 : (lane >> shift_q);
    sat     = |shifted[47:8];
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == EMIT);
  assign out_sat    = out_valid && sat;
  assign out_data   = !out_valid ? 8'h00 : (sat ? 8'hFF : shifted[7:0]);
  assign out_last   = out_valid && (idx_q == last_q);
  assign mode_err   = mode_err_q;
  assign result_cnt = cnt_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Randomized + directed bench for sa_result_drain against a lane/shift reference model.
module tb_sa_result_drain;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [47:0]      in_sum;
  logic [3:0]       mode;
  logic [5:0]       shift;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             out_sat;
  logic             mode_err;
  logic [CNT_W-1:0] result_cnt;

  int errs = 0;
  int checks = 0;
  int exp_cnt = 0;
  bit exp_err = 0;

  sa_result_drain #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .mode(mode), .shift(shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_sat(out_sat), .mode_err(mode_err), .result_cnt(result_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: lane count/width from mode, byte and saturation per lane
  function automatic int n_lanes(input logic [3:0] md);
    return (md == 4'd0) ? 4 : (md == 4'd1) ? 2 : 1;
  endfunction

  function automatic longint ref_val(input logic [47:0] s, input logic [3:0] md,
                                     input int sh, input int k);
    int w;
    longint lane;
    w = 48 / n_lanes(md);
    lane = (longint'(s) >> (k * w)) % (64'd1 << w);
    if (sh >= w) return 0;
    return lane >> sh;
  endfunction

  // Drive one result and check every beat; optional stall on one beat and
  // optional holding of in_valid through the emission.
  task automatic run_result(input logic [47:0] s, input logic [3:0] md, input int sh,
                            input int stall_beat, input int stall_len, input bit hold_valid);
    int L;
    int t;
    longint v;
    logic [7:0] eb;
    L = n_lanes(md);
    in_valid = 1'b1; in_sum = s; mode = md; shift = 6'(sh); out_ready = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) begin chk("capture_timeout", 0, 1); in_valid = 1'b0; return; end
    @(posedge clk);
    #1;
    if (!hold_valid) in_valid = 1'b0;
    mode = 4'($urandom_range(0, 15));
    shift = 6'($urandom);
    if (md > 4'd2) exp_err = 1;
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    for (int k = 0; k < L; k++) begin
      v = ref_val(s, md, sh, k);
      eb = (v > 255) ? 8'hFF : v[7:0];
      if (k == stall_beat) begin
        out_ready = 1'b0;
        for (int c = 0; c < stall_len; c++) begin
          @(negedge clk);
          chk("stall_data", out_data, eb);
          chk("stall_sat", out_sat, v > 255);
          chk("stall_last", out_last, k == L - 1);
          chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      chk("beat_valid", out_valid, 1);
      chk("beat_data", out_data, eb);
      chk("beat_sat", out_sat, v > 255);
      chk("beat_last", out_last, k == L - 1);
      chk("beat_in_ready", in_ready, 0);
      @(negedge clk);
    end
    exp_cnt++;
    chk("drained_valid", out_valid, 0);
    chk("drained_in_ready", in_ready, 1);
    chk("result_cnt", result_cnt, exp_cnt % (1 << CNT_W));
    chk("mode_err", mode_err, exp_err);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; mode = '0; shift = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_mode_err", mode_err, 0);
    chk("rst_result_cnt", result_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Directed vectors
    run_result(48'h0FF_123_800_005, 4'd0, 0, -1, 0, 0);
    run_result(48'h000100_0000FF, 4'd1, 1, -1, 0, 0);
    run_result(48'hAB00_0000_0000, 4'd2, 40, -1, 0, 0);
    run_result(48'hAB00_0000_0000, 4'd2, 48, -1, 0, 0);
    // Backpressure on beat 2 while the engine holds a second result
    run_result(48'h0FF_123_800_005, 4'd0, 0, 1, 3, 1);
    run_result(48'h123_456_789_ABC, 4'd0, 2, -1, 0, 0);

    // Reset mid-stream after the first beat
    in_valid = 1'b1; in_sum = 48'h0FF_123_800_005; mode = 4'd0; shift = 6'd0; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mid_beat0", out_data, 8'h05);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_cnt", result_cnt, 0);
    rst = 1'b0; exp_cnt = 0; exp_err = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid2", out_valid, 0);
    run_result(48'h0FF_123_800_005, 4'd0, 0, -1, 0, 0);

    // Random legal traffic
    for (int i = 0; i < 60; i++)
      run_result({16'($urandom), 32'($urandom)}, 4'($urandom_range(0, 2)),
                 $urandom_range(0, 50), $urandom_range(0, 4), $urandom_range(1, 3),
                 1'($urandom));

    // Illegal mode: one 48-bit lane, sticky error
    run_result(48'h00F0_0000_1234, 4'd7, 30, -1, 0, 0);
    run_result(48'h0FF_123_800_005, 4'd0, 0, -1, 0, 0);

    // Enough results to wrap the counter
    while (exp_cnt < (1 << CNT_W) + 10)
      run_result({16'($urandom), 32'($urandom)}, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 50), -1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
